fifo_stream_reader: RTL and testbench

Read-side consumer for the dual-clock FIFO. It lives entirely in the read clock domain and drives the FIFO's read port (`rinc`, `rdata`, `rempty`). It turns that port into a valid/ready stream with a 2-entry output buffer, sustaining one word per cycle for either FIFO read latency. It also frames the stream into fixed-length packets using `m_last`.

---
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: 2-entry valid/ready output buffer with fixed-length packet framing.
// Define FIFO_READER_STATS_EN to build the saturating delivered-word counter on words_cnt.
module fifo_stream_reader #(
  parameter int    DSIZE       = 8,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    PKT_LEN     = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             drain_en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic [15:0]      words_cnt
);
  localparam bit            LP_FT   = (FALLTHROUGH == "TRUE");
  localparam int            PW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LP_LAST = PW'(PKT_LEN - 1);

  logic [1:0]       r_count;
  logic             r_inflight;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_tail;
  logic [PW-1:0]    r_pkt_idx;
  logic             w_pop;
  logic             w_cap;
  logic [1:0]       w_occ;

  assign w_pop = m_valid && m_ready;
  // Occupancy counts a registered-mode read that is still on its way, so the buffer cannot overflow.
  assign w_occ = r_count + {1'b0, r_inflight};
  assign rinc  = !rrst && drain_en && !rempty && (w_occ < (2'd2 + {1'b0, w_pop}));
  assign w_cap = LP_FT ? rinc : r_inflight;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_pkt_idx  <= '0;
    end else begin
      r_inflight <= LP_FT ? 1'b0 : rinc;
      unique case ({w_cap, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= rdata;
          else                 r_tail <= rdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= rdata;
          end else begin
            r_head <= r_tail;
            r_tail <= rdata;
          end
        end
        default: ;
      endcase
      if (w_pop) r_pkt_idx <= (r_pkt_idx == LP_LAST) ? '0 : r_pkt_idx + PW'(1);
    end
  end

  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_head;
  assign m_last  = m_valid && (r_pkt_idx == LP_LAST);

`ifdef FIFO_READER_STATS_EN
  logic [15:0] r_words_cnt;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)                                    r_words_cnt <= 16'd0;
    else if (w_pop && (r_words_cnt != 16'hFFFF)) r_words_cnt <= r_words_cnt + 16'd1;
  end

  assign words_cnt = r_words_cnt;
`else
  assign words_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: fall-through, registered-read and single-word-packet instances
// checked against a FIFO-order scoreboard with packet index and saturating word count.
module tb_fifo_stream_reader;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ND-1:0]       drain_en, m_ready, rempty, rinc, m_valid, m_last;
  logic [ND-1:0][7:0]  m_data;
  logic [ND-1:0][15:0] words_cnt;
  logic [7:0]          rdata_t, rdata_f, rdata_1;

  logic [7:0]    fmem [ND][1024];
  int            wr[ND], rd[ND], head[ND], pidx[ND], xfers[ND], wcnt[ND];
  logic [ND-1:0] r_pop = '0;
  logic [ND-1:0] hold = '0;
  logic [7:0]    hold_dat[ND];
  int            checks = 0, failures = 0;

  fifo_stream_reader #(.DSIZE(8), .FALLTHROUGH("TRUE"), .PKT_LEN(4)) dut_t (
    .rclk(clk), .rrst(rst), .drain_en(drain_en[0]), .rempty(rempty[0]), .rdata(rdata_t),
    .rinc(rinc[0]), .m_valid(m_valid[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .m_ready(m_ready[0]), .words_cnt(words_cnt[0]));

  fifo_stream_reader #(.DSIZE(8), .FALLTHROUGH("FALSE"), .PKT_LEN(4)) dut_f (
    .rclk(clk), .rrst(rst), .drain_en(drain_en[1]), .rempty(rempty[1]), .rdata(rdata_f),
    .rinc(rinc[1]), .m_valid(m_valid[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .m_ready(m_ready[1]), .words_cnt(words_cnt[1]));

  fifo_stream_reader #(.DSIZE(8), .FALLTHROUGH("TRUE"), .PKT_LEN(1)) dut_1 (
    .rclk(clk), .rrst(rst), .drain_en(drain_en[2]), .rempty(rempty[2]), .rdata(rdata_1),
    .rinc(rinc[2]), .m_valid(m_valid[2]), .m_data(m_data[2]), .m_last(m_last[2]),
    .m_ready(m_ready[2]), .words_cnt(words_cnt[2]));

  // FIFO models: pops latched at the previous falling edge take effect on the rising edge.
  for (genvar g = 0; g < ND; g++) begin : g_empty
    assign rempty[g] = (rd[g] == wr[g]);
  end
  assign rdata_t = fmem[0][rd[0][9:0]];
  assign rdata_1 = fmem[2][rd[2][9:0]];

  always @(posedge clk) begin
    if (r_pop[1]) rdata_f <= fmem[1][rd[1][9:0]];
    for (int d = 0; d < ND; d++) if (r_pop[d]) rd[d] <= rd[d] + 1;
  end

  function automatic int plen(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    fmem[d][wr[d][9:0]] = v;
    wr[d]++;
  endtask

  task automatic mon(input int d);
    int exp_wc;
    if (rst) begin
      head[d] = rd[d]; pidx[d] = 0; wcnt[d] = 0; hold[d] = 1'b0; r_pop[d] = 1'b0;
      return;
    end
    exp_wc = (wcnt[d] > 65535) ? 65535 : wcnt[d];
`ifndef FIFO_READER_STATS_EN
    exp_wc = 0;
`endif
    chk("words_cnt", int'(words_cnt[d]), exp_wc);
    if (hold[d]) begin
      chk("hold_valid", int'(m_valid[d]), 1);
      chk("hold_data", int'(m_data[d]), int'(hold_dat[d]));
    end
    if (d == 2) chk("len1_last_eq_valid", int'(m_last[d]), int'(m_valid[d]));
    if (m_valid[d] && m_ready[d]) begin
      chk("xfer_has_word", int'((rd[d] - head[d]) > 0), 1);
      if (rd[d] > head[d]) begin
        chk("xfer_data", int'(m_data[d]), int'(fmem[d][head[d][9:0]]));
        chk("xfer_last", int'(m_last[d]), int'(pidx[d] == plen(d) - 1));
        head[d]++;
        pidx[d] = (pidx[d] + 1) % plen(d);
        wcnt[d]++;
        xfers[d]++;
      end
    end
    if (!drain_en[d]) chk("rinc_while_paused", int'(rinc[d]), 0);
    r_pop[d] = rinc[d];
    chk("occupancy_le2", int'((rd[d] + int'(rinc[d]) - head[d]) <= 2), 1);
    hold[d]     = m_valid[d] && !m_ready[d];
    hold_dat[d] = m_data[d];
  endtask

  task automatic finish_cycle();
    for (int d = 0; d < ND; d++) mon(d);
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    finish_cycle();
  endtask

  typedef struct {
    logic       en, rdy, e_rinc, e_valid;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t tbl[13];
  int   snap;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h21, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h23, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h24, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h25, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h26, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h27, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h27, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rst = 1'b1; drain_en = '0; m_ready = '0;
    @(posedge clk); #1;

    // reset held 3 cycles, then idle with every FIFO empty
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b0; drain_en = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk("idle_valid", int'(m_valid[d]), 0);
        chk("idle_rinc", int'(rinc[d]), 0);
        chk("idle_last", int'(m_last[d]), 0);
        chk("idle_data", int'(m_data[d]), 0);
      end
      finish_cycle();
    end

    // fall-through stream 0x00..0x07 at full rate
    for (int i = 0; i < 8; i++) push(0, 8'(i));
    m_ready[0] = 1'b1;
    @(negedge clk);
    chk("ft_first_rinc", int'(rinc[0]), 1);
    chk("ft_first_valid", int'(m_valid[0]), 0);
    finish_cycle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ft_stream_valid", int'(m_valid[0]), 1);
      chk("ft_stream_data", int'(m_data[0]), i);
      chk("ft_stream_last", int'(m_last[0]), int'(i % 4 == 3));
      finish_cycle();
    end
    @(negedge clk);
    chk("ft_stream_end", int'(m_valid[0]), 0);
    finish_cycle();

    // table: fall-through with backpressure and pause
    drain_en[0] = 1'b0;
    for (int i = 0; i < 8; i++) push(0, 8'(8'h20 + i));
    for (int i = 0; i < 13; i++) begin
      drain_en[0] = tbl[i].en;
      m_ready[0]  = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_rinc", int'(rinc[0]), int'(tbl[i].e_rinc));
      chk("tbl_valid", int'(m_valid[0]), int'(tbl[i].e_valid));
      chk("tbl_last", int'(m_last[0]), int'(tbl[i].e_last));
      if (tbl[i].e_valid) chk("tbl_data", int'(m_data[0]), int'(tbl[i].e_data));
      finish_cycle();
    end
    drain_en[0] = 1'b1;

    // registered-read latency: rinc in N, m_valid in N+2
    m_ready[1] = 1'b1;
    push(1, 8'hA5);
    @(negedge clk);
    chk("rg_lat_rinc0", int'(rinc[1]), 1);
    chk("rg_lat_valid0", int'(m_valid[1]), 0);
    finish_cycle();
    @(negedge clk);
    chk("rg_lat_rinc1", int'(rinc[1]), 0);
    chk("rg_lat_valid1", int'(m_valid[1]), 0);
    finish_cycle();
    @(negedge clk);
    chk("rg_lat_valid2", int'(m_valid[1]), 1);
    chk("rg_lat_data2", int'(m_data[1]), 8'hA5);
    finish_cycle();
    @(negedge clk);
    chk("rg_lat_valid3", int'(m_valid[1]), 0);
    finish_cycle();

    // registered-read with alternating m_ready
    for (int i = 0; i < 10; i++) push(1, 8'(8'h30 + i));
    for (int i = 0; i < 40; i++) begin
      m_ready[1] = (i % 2 == 0);
      cyc();
    end
    chk("bp_all_delivered", head[1], wr[1]);

    // drain pause: the in-flight word is still delivered, nothing new fetched
    m_ready[1] = 1'b1;
    for (int i = 0; i < 8; i++) push(1, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) cyc();
    drain_en[1] = 1'b0;
    snap = rd[1];
    for (int i = 0; i < 5; i++) cyc();
    chk("pause_no_fetch", rd[1], snap);
    chk("pause_inflight_delivered", head[1], snap);
    drain_en[1] = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    chk("pause_resume_delivered", head[1], wr[1]);

    // registered-read sustained throughput
    for (int i = 0; i < 12; i++) push(1, 8'(8'h70 + i));
    for (int i = 0; i < 6 && !m_valid[1]; i++) cyc();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rg_throughput_valid", int'(m_valid[1]), 1);
      finish_cycle();
    end

    // reset in the middle of a packet
    for (int i = 0; i < 8; i++) push(1, 8'(8'h90 + i));
    for (int i = 0; i < 20 && pidx[1] != 2; i++) cyc();
    chk("mid_pkt_reached", pidx[1], 2);
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_valid", int'(m_valid[d]), 0);
      chk("rst_data", int'(m_data[d]), 0);
      chk("rst_last", int'(m_last[d]), 0);
      chk("rst_rinc", int'(rinc[d]), 0);
    end
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("post_rst_delivered", head[1], wr[1]);

    // randomized traffic on all instances
    for (int i = 0; i < 1000; i++) begin
      for (int d = 0; d < ND; d++) begin
        if ($urandom_range(0, 2) == 0 && (wr[d] - rd[d]) < 200) push(d, 8'($urandom_range(0, 255)));
        m_ready[d]  = ($urandom_range(0, 3) != 0);
        drain_en[d] = ($urandom_range(0, 7) != 0);
      end
      cyc();
    end
    drain_en = '1; m_ready = '1;
    for (int i = 0; i < 500 && (head[0] != wr[0] || head[1] != wr[1] || head[2] != wr[2]); i++) cyc();
    for (int d = 0; d < ND; d++) chk("rand_all_delivered", head[d], wr[d]);

`ifdef FIFO_READER_STATS_EN
    for (int i = 0; i < 70000; i++) begin
      push(2, 8'(i));
      cyc();
    end
    for (int i = 0; i < 5; i++) cyc();
    chk("stats_saturated", int'(words_cnt[2]), 16'hFFFF);
`else
    chk("stats_disabled", int'(words_cnt[2]), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
